// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: owner tags, FSM states, request bundle.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dmem_pkg;

  localparam int DMEM_AW = 32;
  localparam int DMEM_DW = 32;

  // Who owns the read response returning from memory next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_D    = 2'b01,
    OWN_I    = 2'b10
  } owner_e;

  // Arbitration priority state.
  typedef enum logic {
    PRIO_D = 1'b0,
    PRIO_I = 1'b1
  } prio_state_e;

  // One requester's access fields. The top-level AW/DW parameters must
  // match DMEM_AW/DMEM_DW because these fields carry the full bus.
  typedef struct packed {
    logic               we;
    logic               half;
    logic               byte_op;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_arb_prio.sv
// Priority pick between port D and port I with a starvation guard for port I.
// Latency: grants are combinational in the request cycle; state updates at the edge.
// Backpressure: a denied requester simply holds its request; no queuing here.
//
// Ports: clk, rst_n (async active-low), d_req/i_req in, d_gnt/i_gnt out,
//        state out (current priority, exposed for observability).
module dmem_arb_prio
  import dmem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_req,
  input  logic        i_req,
  output logic        d_gnt,
  output logic        i_gnt,
  output prio_state_e state
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX - 1);

  logic [3:0] starve_cnt;
  logic       i_denied;
  logic       starved;

  // Grants are suppressed while reset is asserted so every output reads 0
  // during reset even if requesters keep their lines high.
  always_comb begin
    d_gnt = 1'b0;
    i_gnt = 1'b0;
    if (rst_n) begin
      if (state == PRIO_D) begin
        if (d_req)      d_gnt = 1'b1;
        else if (i_req) i_gnt = 1'b1;
      end else begin
        if (i_req)      i_gnt = 1'b1;
        else if (d_req) d_gnt = 1'b1;
      end
    end
  end

  assign i_denied = i_req && !i_gnt;
  assign starved  = i_denied && (starve_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PRIO_D;
      starve_cnt <= 4'd0;
    end else begin
      case (state)
        PRIO_D:  if (starved) state <= PRIO_I;
        default: state <= PRIO_D;  // PRIO_I lasts exactly one cycle
      endcase

      // Counts consecutive denials; any grant or a dropped request clears it.
      if (i_denied) begin
        if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory with read-response routing.
// Latency: grant and memory drive combinational; read data returns one cycle after grant.
// Backpressure: losing port holds req until granted; responses cannot be stalled.
//
// Ports: clk, rst_n (async active-low);
//        port D / port I: *_req, *_we, *_half, *_byte, *_addr, *_wdata in;
//                         *_gnt, *_rvalid, *_rdata out;
//        memory: mem_addr, mem_write, mem_read, mem_half, mem_byte, mem_wdata out,
//                mem_rdata in; err out (granted request with half and byte both set).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW         = DMEM_AW,
  parameter int DW         = DMEM_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_half,
  input  logic          d_byte,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,

  input  logic          i_req,
  input  logic          i_we,
  input  logic          i_half,
  input  logic          i_byte,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,

  output logic [AW-1:0] mem_addr,
  output logic          mem_write,
  output logic          mem_read,
  output logic          mem_half,
  output logic          mem_byte,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          err
);

  req_t        d_r;
  req_t        i_r;
  req_t        win;
  logic        any_gnt;
  owner_e      rd_owner;
  prio_state_e prio_state;

  dmem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk   (clk),
    .rst_n (rst_n),
    .d_req (d_req),
    .i_req (i_req),
    .d_gnt (d_gnt),
    .i_gnt (i_gnt),
    .state (prio_state)
  );

  assign d_r = '{we: d_we, half: d_half, byte_op: d_byte, addr: d_addr, wdata: d_wdata};
  assign i_r = '{we: i_we, half: i_half, byte_op: i_byte, addr: i_addr, wdata: i_wdata};

  // Zero fields when nobody is granted keeps the memory bus quiet.
  always_comb begin
    win = '0;
    if (d_gnt)      win = d_r;
    else if (i_gnt) win = i_r;
  end

  assign any_gnt   = d_gnt | i_gnt;
  assign mem_addr  = win.addr;
  assign mem_wdata = win.wdata;
  assign mem_write = any_gnt &  win.we;
  assign mem_read  = any_gnt & ~win.we;
  // half&&byte is illegal; half wins so the access width stays well defined.
  assign mem_half  = win.half;
  assign mem_byte  = win.byte_op & ~win.half;
  assign err       = any_gnt & win.half & win.byte_op;

  // Remember who issued this cycle's read so next cycle's data goes home.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner <= OWN_NONE;
    end else if (mem_read) begin
      rd_owner <= d_gnt ? OWN_D : OWN_I;
    end else begin
      rd_owner <= OWN_NONE;
    end
  end

  assign d_rvalid = (rd_owner == OWN_D);
  assign i_rvalid = (rd_owner == OWN_I);
  assign d_rdata  = d_rvalid ? mem_rdata : '0;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        d_req, d_we, d_half, d_byte;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        i_req, i_we, i_half, i_byte;
  logic [31:0] i_addr, i_wdata;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read, mem_half, mem_byte;
  logic        err;

  int checks   = 0;
  int failures = 0;

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_req(d_req), .d_we(d_we), .d_half(d_half), .d_byte(d_byte),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .i_req(i_req), .i_we(i_we), .i_half(i_half), .i_byte(i_byte),
    .i_addr(i_addr), .i_wdata(i_wdata),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
    .mem_half(mem_half), .mem_byte(mem_byte), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: 64 words, little-endian lanes, registered word read.
  logic [31:0] mem [64];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] a, input logic h, input logic b);
    logic [31:0] w;
    w = old;
    if (h) begin
      if (a[1]) w[31:16] = wd[15:0];
      else      w[15:0]  = wd[15:0];
    end else if (b) begin
      case (a)
        2'd0:    w[7:0]   = wd[7:0];
        2'd1:    w[15:8]  = wd[7:0];
        2'd2:    w[23:16] = wd[7:0];
        default: w[31:24] = wd[7:0];
      endcase
    end else begin
      w = wd;
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (mem_write)
      mem[mem_addr[7:2]] <= merge(mem[mem_addr[7:2]], mem_wdata, mem_addr[1:0], mem_half, mem_byte);
    if (mem_read)
      mem_rdata <= mem[mem_addr[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic req, input logic we, input logic h, input logic b,
                       input logic [31:0] a, input logic [31:0] wd);
    d_req = req; d_we = we; d_half = h; d_byte = b; d_addr = a; d_wdata = wd;
  endtask

  task automatic set_i(input logic req, input logic we, input logic h, input logic b,
                       input logic [31:0] a, input logic [31:0] wd);
    i_req = req; i_we = we; i_half = h; i_byte = b; i_addr = a; i_wdata = wd;
  endtask

  // Inputs change just after the rising edge; checks happen on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'h0;
    mem[0] = 32'hFF5400A4;
    mem[1] = 32'h96545EA4;
    mem_rdata = 32'h0;
    rst_n = 1'b0;
    set_d(0, 0, 0, 0, 0, 0);
    set_i(0, 0, 0, 0, 0, 0);

    // Reset state
    @(negedge clk);
    chk("rst_d_gnt", {31'b0, d_gnt}, 0);
    chk("rst_i_gnt", {31'b0, i_gnt}, 0);
    chk("rst_mem_rd", {31'b0, mem_read}, 0);
    chk("rst_mem_wr", {31'b0, mem_write}, 0);
    chk("rst_d_rvalid", {31'b0, d_rvalid}, 0);
    chk("rst_err", {31'b0, err}, 0);
    rst_n = 1'b1;

    // Single D word read of address 0
    next_cycle();
    set_d(1, 0, 0, 0, 32'h0, 0);
    @(negedge clk);
    chk("t1_d_gnt", {31'b0, d_gnt}, 1);
    chk("t1_mem_read", {31'b0, mem_read}, 1);
    chk("t1_mem_write", {31'b0, mem_write}, 0);
    next_cycle();
    set_d(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1_d_rvalid", {31'b0, d_rvalid}, 1);
    chk("t1_d_rdata", d_rdata, 32'hFF5400A4);
    chk("t1_i_rvalid", {31'b0, i_rvalid}, 0);
    chk("t1_i_rdata", i_rdata, 0);
    next_cycle();
    @(negedge clk);
    chk("t1_idle_mem_addr", mem_addr, 0);
    chk("t1_idle_d_rvalid", {31'b0, d_rvalid}, 0);

    // Simultaneous requests: D wins, I follows while D's data returns
    next_cycle();
    set_d(1, 0, 0, 0, 32'h4, 0);
    set_i(1, 0, 0, 0, 32'h0, 0);
    @(negedge clk);
    chk("t2_d_gnt", {31'b0, d_gnt}, 1);
    chk("t2_i_gnt", {31'b0, i_gnt}, 0);
    chk("t2_mem_addr", mem_addr, 32'h4);
    next_cycle();
    set_d(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t2_d_rvalid", {31'b0, d_rvalid}, 1);
    chk("t2_d_rdata", d_rdata, 32'h96545EA4);
    chk("t2_i_gnt_next", {31'b0, i_gnt}, 1);
    chk("t2_i_rdata_nonowner", i_rdata, 0);
    next_cycle();
    set_i(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t2_i_rvalid", {31'b0, i_rvalid}, 1);
    chk("t2_i_rdata", i_rdata, 32'hFF5400A4);
    chk("t2_d_rvalid_off", {31'b0, d_rvalid}, 0);

    // Starvation guard: both held, I forced on cycle 5 and 10
    next_cycle();
    set_d(1, 0, 0, 0, 32'h0, 0);
    set_i(1, 0, 0, 0, 32'h4, 0);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk($sformatf("t3_i_gnt_c%0d", c), {31'b0, i_gnt}, (c == 5 || c == 10) ? 1 : 0);
      chk($sformatf("t3_d_gnt_c%0d", c), {31'b0, d_gnt}, (c == 5 || c == 10) ? 0 : 1);
      if (c == 6) chk("t3_i_rvalid_after_force", {31'b0, i_rvalid}, 1);
      if (c < 11) next_cycle();
    end
    next_cycle();
    set_d(0, 0, 0, 0, 0, 0);
    set_i(0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // I word write, then D read-after-write, with I byte write in parallel
    next_cycle();
    set_i(1, 1, 0, 0, 32'h8, 32'hDEADBEEF);
    @(negedge clk);
    chk("t4_i_gnt_wr", {31'b0, i_gnt}, 1);
    chk("t4_mem_write", {31'b0, mem_write}, 1);
    chk("t4_mem_read", {31'b0, mem_read}, 0);
    chk("t4_mem_wdata", mem_wdata, 32'hDEADBEEF);
    next_cycle();
    set_i(0, 0, 0, 0, 0, 0);
    set_d(1, 0, 0, 0, 32'h8, 0);
    @(negedge clk);
    chk("t4_wr_no_rvalid", {31'b0, i_rvalid}, 0);
    chk("t4_d_gnt_rd", {31'b0, d_gnt}, 1);
    next_cycle();
    set_d(0, 0, 0, 0, 0, 0);
    set_i(1, 1, 0, 1, 32'h9, 32'h00000055);
    @(negedge clk);
    chk("t4_raw_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("t4_byte_gnt", {31'b0, i_gnt}, 1);
    chk("t4_mem_byte", {31'b0, mem_byte}, 1);
    next_cycle();
    set_i(1, 0, 0, 0, 32'h8, 0);
    @(negedge clk);
    chk("t4_i_gnt_rd", {31'b0, i_gnt}, 1);
    next_cycle();
    set_i(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4_byte_merge", i_rdata, 32'hDEAD55EF);

    // Illegal half+byte: still granted, driven as half, err pulses once
    next_cycle();
    set_d(1, 0, 1, 1, 32'h0, 0);
    @(negedge clk);
    chk("t5_d_gnt", {31'b0, d_gnt}, 1);
    chk("t5_err", {31'b0, err}, 1);
    chk("t5_mem_half", {31'b0, mem_half}, 1);
    chk("t5_mem_byte", {31'b0, mem_byte}, 0);
    next_cycle();
    set_d(1, 0, 0, 0, 32'h4, 0);
    @(negedge clk);
    chk("t5_err_clear", {31'b0, err}, 0);
    next_cycle();
    set_d(0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset mid-operation: in-flight read dropped, counter and FSM cleared
    next_cycle();
    set_d(1, 0, 0, 0, 32'h0, 0);
    set_i(1, 0, 0, 0, 32'h4, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("t6_pre_d_gnt_c%0d", c), {31'b0, d_gnt}, 1);
      if (c < 4) next_cycle();
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_d_rvalid", {31'b0, d_rvalid}, 0);
    chk("t6_rst_d_gnt", {31'b0, d_gnt}, 0);
    chk("t6_rst_i_gnt", {31'b0, i_gnt}, 0);
    chk("t6_rst_mem_read", {31'b0, mem_read}, 0);
    chk("t6_rst_d_rdata", d_rdata, 0);
    rst_n = 1'b1;
    #1;
    chk("t6_post_d_gnt", {31'b0, d_gnt}, 1);
    chk("t6_post_i_gnt", {31'b0, i_gnt}, 0);
    chk("t6_post_d_rvalid", {31'b0, d_rvalid}, 0);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("t6_post_i_gnt_c%0d", c), {31'b0, i_gnt}, (c == 5) ? 1 : 0);
    end
    next_cycle();
    set_d(0, 0, 0, 0, 0, 0);
    set_i(0, 0, 0, 0, 0, 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
